// File: rtl/scamp_mem_pkg.sv
// Shared definitions for the SRAM byte sequencer and its phase timer.
//   seq_state_t : sequencer FSM states
//   lane_t      : byte lane index within a 16-bit word (0 = low byte)
//   WAIT_CYCLES_MIN/MAX : legal range of strobe-low cycles per byte access
package scamp_mem_pkg;

    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } seq_state_t;

    typedef logic lane_t;

    localparam lane_t LANE_LO = 1'b0;
    localparam lane_t LANE_HI = 1'b1;

endpackage

// File: rtl/sram_phase_timer.sv
// Strobe-length down-counter.
//   clk, reset  : system clock, synchronous active-high reset
//   load        : loads load_count (strobe length minus one)
//   load_count  : 3-bit start value
//   done        : terminal count reached; marks the last strobe cycle
module sram_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_count,
    output logic       done
);
    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_count;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign done = (count == 3'd0);

endmodule

// File: rtl/sram_byte_sequencer.sv
// Splits 16-bit word requests into two byte accesses on an 8-bit async SRAM.
//   clk, reset        : system clock, synchronous active-high reset
//   req_*             : word request (valid/ready handshake, we, 15-bit addr, wdata)
//   rsp_valid/rdata   : one-cycle completion pulse and read data
//   sram_addr/dout    : byte address and write byte
//   sram_dout_en      : enable for the external bus buffer
//   sram_din          : byte read from the SRAM bus
//   sram_cs1_bar/cs2/we_bar/oe_bar : SRAM control pins
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | ready for a request, chip deselected
// ST_SETUP  | address/data settle, strobes inactive, load timer
// ST_STROBE | we_bar or oe_bar low for WAIT_CYCLES cycles
// ST_HOLD   | strobes released, address/data still held
// ST_DONE   | rsp_valid pulse, then back to IDLE
module sram_byte_sequencer
    import scamp_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [14:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en,
    input  logic [7:0]  sram_din,
    output logic        sram_cs1_bar,
    output logic        sram_cs2,
    output logic        sram_we_bar,
    output logic        sram_oe_bar
);
    // Out-of-range settings are clamped so the 3-bit timer never wraps.
    localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN :
                              (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam logic [2:0] STROBE_LOAD = 3'(WAIT_EFF - 1);

    seq_state_t  state, state_nxt;
    lane_t       lane;
    logic        we_q;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        timer_done;
    logic        active;
    logic        capture;

    sram_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state == ST_SETUP),
        .load_count (STROBE_LOAD),
        .done       (timer_done)
    );

    assign capture = (state == ST_STROBE) && timer_done && !we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lane    <= LANE_LO;
            we_q    <= 1'b0;
            addr_q  <= 15'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                lane    <= LANE_LO;
            end
            // After lane 0 HOLD we go on to lane 1; after lane 1 it simply stays 1.
            if (state == ST_HOLD) begin
                lane <= LANE_HI;
            end
            if (capture) begin
                if (lane == LANE_HI) begin
                    rdata_q[15:8] <= sram_din;
                end else begin
                    rdata_q[7:0] <= sram_din;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: if (timer_done) state_nxt = ST_HOLD;
            ST_HOLD:   state_nxt = (lane == LANE_HI) ? ST_DONE : ST_SETUP;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign active       = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
    assign req_ready    = (state == ST_IDLE);
    assign rsp_valid    = (state == ST_DONE);
    assign rsp_rdata    = rdata_q;
    assign sram_addr    = {addr_q, lane};
    assign sram_dout    = (lane == LANE_HI) ? wdata_q[15:8] : wdata_q[7:0];
    assign sram_dout_en = active && we_q;
    assign sram_cs1_bar = !active;
    assign sram_cs2     = active;
    assign sram_we_bar  = !((state == ST_STROBE) && we_q);
    assign sram_oe_bar  = !((state == ST_STROBE) && !we_q);

endmodule

// File: tb/tb_sram_byte_sequencer.sv
// Scoreboard bench: two sequencers (WAIT_CYCLES=1 and 3), each on its own
// 64k x 8 SRAM model behind a bus buffer modelled as a mux.
module tb_sram_byte_sequencer;

    typedef struct {
        int          inst;
        int          cyc;
        logic [15:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [14:0] req_addr     [2];
    logic [15:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [15:0] rsp_rdata    [2];
    logic [15:0] sram_addr    [2];
    logic [7:0]  sram_dout    [2];
    logic        sram_dout_en [2];
    logic [7:0]  sram_din     [2];
    logic        cs1_bar      [2];
    logic        cs2          [2];
    logic        we_bar       [2];
    logic        oe_bar       [2];

    logic [7:0]  mem [2][65536];
    int          wr_cnt [2];
    int          cyc;
    int          checks;
    int          failures;
    exp_t        exp_q[$];
    logic [15:0] last_rd [2];
    int          we_len [2];
    int          oe_len [2];

    sram_byte_sequencer #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .sram_addr(sram_addr[0]),
        .sram_dout(sram_dout[0]), .sram_dout_en(sram_dout_en[0]), .sram_din(sram_din[0]),
        .sram_cs1_bar(cs1_bar[0]), .sram_cs2(cs2[0]), .sram_we_bar(we_bar[0]),
        .sram_oe_bar(oe_bar[0])
    );

    sram_byte_sequencer #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .sram_addr(sram_addr[1]),
        .sram_dout(sram_dout[1]), .sram_dout_en(sram_dout_en[1]), .sram_din(sram_din[1]),
        .sram_cs1_bar(cs1_bar[1]), .sram_cs2(cs2[1]), .sram_we_bar(we_bar[1]),
        .sram_oe_bar(oe_bar[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: write on each strobe edge, bus driven by sequencer or SRAM.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset[i]) begin
                wr_cnt[i] <= 0;
            end else if (!cs1_bar[i] && cs2[i] && !we_bar[i]) begin
                mem[i][sram_addr[i]] <= sram_din[i];
                wr_cnt[i] <= wr_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sram_din[i] = 8'hFF;
            if (sram_dout_en[i]) begin
                sram_din[i] = sram_dout[i];
            end else if (!cs1_bar[i] && cs2[i] && !oe_bar[i]) begin
                sram_din[i] = mem[i][sram_addr[i]];
            end
        end
    end

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void chk(input string nm, input int i, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cycle=%0d actual=0x%0h required=0x%0h", nm, i, cyc, act, exp);
        end
    endfunction

    // Monitor: scoreboard pops, strobe widths, bus contention.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   idx[$];
            exp_t e;
            if (rsp_valid[i]) begin
                idx = exp_q.find_first_index(x) with (x.inst == i);
                if (idx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp inst=%0d cycle=%0d actual=1 required=0", i, cyc);
                end else begin
                    e = exp_q[idx[0]];
                    exp_q.delete(idx[0]);
                    chk("rsp_cycle", i, cyc, e.cyc);
                    chk("rsp_rdata", i, {16'd0, rsp_rdata[i]}, {16'd0, e.rdata});
                end
            end
            if (sram_dout_en[i]) chk("oe_during_dout_en", i, {31'd0, oe_bar[i]}, 32'd1);
            if (!oe_bar[i]) chk("dout_en_during_oe", i, {31'd0, sram_dout_en[i]}, 32'd0);
            if (!we_bar[i]) begin
                we_len[i]++;
            end else if (we_len[i] > 0) begin
                chk("we_pulse_len", i, we_len[i], wc(i));
                we_len[i] = 0;
            end
            if (!oe_bar[i]) begin
                oe_len[i]++;
            end else if (oe_len[i] > 0) begin
                chk("oe_pulse_len", i, oe_len[i], wc(i));
                oe_len[i] = 0;
            end
        end
    end

    task automatic issue(input int i, input bit we, input logic [14:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input bit keep, output int t_hs);
        exp_t e;
        bit   got;
        got = 1'b0;
        t_hs = -1;
        req_we[i] = we;
        req_addr[i] = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout inst=%0d actual=no_ready required=ready", i);
            req_valid[i] = 1'b0;
            return;
        end
        t_hs = cyc;
        e.inst = i;
        e.cyc = cyc + 5 + 2 * wc(i);
        if (!we) last_rd[i] = exp_rd;
        e.rdata = last_rd[i];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 20 && !req_ready[i]; k++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        chk("rst_req_ready", i, {31'd0, req_ready[i]}, 32'd1);
        chk("rst_rsp_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
        chk("rst_rsp_rdata", i, {16'd0, rsp_rdata[i]}, 32'h0);
        chk("rst_sram_addr", i, {16'd0, sram_addr[i]}, 32'h0);
        chk("rst_sram_dout", i, {24'd0, sram_dout[i]}, 32'h0);
        chk("rst_dout_en", i, {31'd0, sram_dout_en[i]}, 32'd0);
        chk("rst_cs1_bar", i, {31'd0, cs1_bar[i]}, 32'd1);
        chk("rst_cs2", i, {31'd0, cs2[i]}, 32'd0);
        chk("rst_we_bar", i, {31'd0, we_bar[i]}, 32'd1);
        chk("rst_oe_bar", i, {31'd0, oe_bar[i]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, w0;
        cyc = 0;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            req_valid[i] = 1'b1;
            req_we[i] = 1'b1;
            req_addr[i] = 15'h1234;
            req_wdata[i] = 16'hFFFF;
            last_rd[i] = 16'h0000;
            we_len[i] = 0;
            oe_len[i] = 0;
        end
        // Reset wins over a simultaneous request.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            reset[i] = 1'b0;
        end

        // W=1 write 0x1234 to word 0x0010, then read back.
        issue(0, 1'b1, 15'h0010, 16'h1234, 16'h0, 1'b0, t);
        wait_idle(0);
        chk("mem_0020", 0, {24'd0, mem[0][16'h0020]}, 32'h34);
        chk("mem_0021", 0, {24'd0, mem[0][16'h0021]}, 32'h12);
        issue(0, 1'b0, 15'h0010, 16'hDEAD, 16'h1234, 1'b0, t);
        wait_idle(0);

        // Busy: request held with changing fields; only the latched write happens.
        w0 = wr_cnt[0];
        issue(0, 1'b1, 15'h0020, 16'h5678, 16'h0, 1'b1, t);
        for (int k = 1; k <= 7; k++) begin
            req_addr[0] = 15'h0030 + 15'(k);
            req_wdata[0] = 16'hA500 + 16'(k);
            req_we[0] = k[0];
            @(negedge clk);
            chk("busy_ready_low", 0, {31'd0, req_ready[0]}, 32'd0);
            if (k == 7) req_valid[0] = 1'b0;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("ready_after_done", 0, {31'd0, req_ready[0]}, 32'd1);
        chk("busy_write_count", 0, wr_cnt[0] - w0, 32'd2);
        chk("mem_0040", 0, {24'd0, mem[0][16'h0040]}, 32'h78);
        chk("mem_0041", 0, {24'd0, mem[0][16'h0041]}, 32'h56);
        @(posedge clk);
        #1;
        issue(0, 1'b0, 15'h0020, 16'h0, 16'h5678, 1'b0, t);
        wait_idle(0);

        // Back-to-back write then read with req_valid held high.
        issue(0, 1'b1, 15'h0100, 16'hCAFE, 16'h0, 1'b1, t);
        issue(0, 1'b0, 15'h0100, 16'h0, 16'hCAFE, 1'b0, t2);
        chk("b2b_second_hs", 0, t2 - t, 32'd8);
        wait_idle(0);

        // Reset during lane-1 STROBE of a write.
        issue(0, 1'b1, 15'h0200, 16'h9A5B, 16'h0, 1'b0, t);
        while (cyc < t + 5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_reset_we_low", 0, {31'd0, we_bar[0]}, 32'd0);
        chk("pre_reset_addr", 0, {16'd0, sram_addr[0]}, 32'h0401);
        reset[0] = 1'b1;
        for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].inst == 0) exp_q.delete(k);
        last_rd[0] = 16'h0000;
        @(negedge clk);
        check_reset(0);
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        chk("abort_lane0_byte", 0, {24'd0, mem[0][16'h0400]}, 32'h5B);
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b0, 15'h0010, 16'h0, 16'h1234, 1'b0, t);
        wait_idle(0);

        // W=3: wrap address, write then read.
        issue(1, 1'b1, 15'h7FFF, 16'hBEEF, 16'h0, 1'b0, t);
        wait_idle(1);
        chk("mem_FFFE", 1, {24'd0, mem[1][16'hFFFE]}, 32'hEF);
        chk("mem_FFFF", 1, {24'd0, mem[1][16'hFFFF]}, 32'hBE);
        issue(1, 1'b0, 15'h7FFF, 16'h0, 16'hBEEF, 1'b0, t);
        wait_idle(1);

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_rsp actual=%0d_pending required=0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_byte_sequencer.md
SRAM_BYTE_SEQUENCER -- requirements
Module: sram_byte_sequencer

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of strobe-low cycles per byte access (legal range 1..7).
REQ-002 SHALL have clk  in  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have req_valid  in  1  word request present.
REQ-005 SHALL have req_ready  out  1  sequencer can accept a request.
REQ-006 SHALL have req_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have req_addr  in  15  word address.
REQ-008 SHALL have req_wdata  in  16  write data.
REQ-009 SHALL have rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have rsp_rdata  out  16  read data.
REQ-011 SHALL have sram_addr  out  16  SRAM byte address.
REQ-012 SHALL have sram_dout  out  8  byte to be driven onto the SRAM data bus.
REQ-013 SHALL have sram_dout_en  out  1  tri-state enable for sram_dout; the bus buffer itself sits outside this block.
REQ-014 SHALL have sram_din  in  8  byte read from the SRAM data bus.
REQ-015 SHALL have sram_cs1_bar, sram_cs2, sram_we_bar, sram_oe_bar  out  1 each  SRAM control pins.

Function
REQ-016 SHALL use the FSM states IDLE, SETUP, STROBE, HOLD and DONE, all registered.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake occurs when req_valid=1 and req_ready=1, and the request fields are latched on that edge.
REQ-018 SHALL sequence each word as two byte accesses: lane 0 at sram_addr={addr,0} carrying data[7:0], then lane 1 at sram_addr={addr,1} carrying data[15:8].
REQ-019 SHALL follow this per-lane sequence: SETUP for 1 cycle, then STROBE for WAIT_CYCLES cycles, then HOLD for 1 cycle.
REQ-020 SHALL go from HOLD of lane 0 to SETUP of lane 1, and from HOLD of lane 1 to DONE (1 cycle), then to IDLE.
REQ-021 SHALL keep sram_addr and sram_dout stable from SETUP through HOLD of each lane.
REQ-022 SHALL drive sram_cs1_bar=0 and sram_cs2=1 in SETUP, STROBE and HOLD, and sram_cs1_bar=1 and sram_cs2=0 otherwise.
REQ-023 SHALL drive sram_we_bar=0 only in STROBE of a write, and sram_oe_bar=0 only in STROBE of a read.
REQ-024 SHALL drive sram_dout_en=1 only in SETUP, STROBE and HOLD of a write; sram_dout_en and an active sram_oe_bar SHALL never coincide.
REQ-025 SHALL capture sram_din on a read on the last STROBE cycle of each lane (lane 0 into rsp_rdata[7:0], lane 1 into rsp_rdata[15:8]).
REQ-026 SHALL leave rsp_rdata unchanged on writes, and SHALL hold it until the next read overwrites it.
REQ-027 SHALL assert rsp_valid=1 in DONE only, for reads and writes alike; with the handshake at cycle T, rsp_valid is high in cycle T+5+2*WAIT_CYCLES.
REQ-028 SHALL make the next handshake possible no earlier than the cycle after DONE.
REQ-029 SHALL ignore req_valid and changes to the request inputs while busy.
REQ-030 SHALL map word address 0x7FFF to byte addresses 0xFFFE and 0xFFFF; no carry or wrap beyond 16 bits exists.

Reset
REQ-031 SHALL, on reset, enter IDLE on that edge with no further strobes, even mid-access.
REQ-032 SHALL produce no rsp_valid for an aborted request.
REQ-033 SHALL give these values while reset is asserted and after it: req_ready=1, rsp_valid=0, rsp_rdata=0x0000, sram_addr=0x0000, sram_dout=0x00, sram_dout_en=0, sram_cs1_bar=1, sram_cs2=0, sram_we_bar=1, sram_oe_bar=1.
REQ-034 SHALL give reset priority over a simultaneous req_valid.

Structure
REQ-035 SHALL place the FSM state enum, the lane index type and the WAIT_CYCLES legal-range constants in the shared package scamp_mem_pkg.
REQ-036 SHALL implement the strobe-length down-counter as one sub-module, sram_phase_timer, with load, done and a 3-bit count.
REQ-037 SHALL be exercised by a bench that instantiates the sequencer against the team's 64k x 8 SRAM model through a tri-state bus buffer.

Verification
REQ-038 SHALL cover a write: W=1, write 0x1234 to word 0x0010 -> byte 0x0020=0x34 and byte 0x0021=0x12, each we_bar pulse exactly 1 cycle, rsp_valid at T+7.
REQ-039 SHALL cover a read-back: read word 0x0010 -> rsp_rdata=0x1234, oe_bar low 1 cycle per lane, sram_dout_en=0 throughout.
REQ-040 SHALL cover wrap: W=3, write 0xBEEF to word 0x7FFF then read it -> bytes 0xFFFE=0xEF and 0xFFFF=0xBE, read returns 0xBEEF, rsp_valid at T+11.
REQ-041 SHALL cover busy: req_valid held high with changing addr/data during an access -> exactly one access, the latched one; req_ready=0 until after DONE.
REQ-042 SHALL cover reset mid-write: reset asserted during lane-1 STROBE -> next cycle all strobes inactive, no rsp_valid, lane-0 byte written and lane-1 byte undefined.
REQ-043 SHALL cover back-to-back traffic: write then read issued with req_valid continuously high -> second handshake in the cycle after DONE, correct data, no overlap of sram_dout_en and oe.
